memc_deskew: RTL and testbench
==============================

MEMC_DESKEW -- requirements
Module: memc_deskew

Interface
REQ-001 SHALL have parameter BITS_C, default 24, signed width of each result element.
REQ-002 SHALL have parameter DIM, default 8, array dimension (rows = columns = DIM); legal range 2..16.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a collection pass; honoured only in IDLE.
REQ-006 SHALL have port in_en  input  1  qualifies Cin as one skewed input beat.
REQ-007 SHALL have port Cin  input  signed [BITS_C-1:0] x DIM  skewed result columns leaving the systolic array.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the current row.
REQ-009 SHALL have port out_valid  output  1  Cout/out_row hold a valid de-skewed row.
REQ-010 SHALL have port Cout  output  signed [BITS_C-1:0] x DIM  one aligned result row.
REQ-011 SHALL have port out_row  output  [$clog2(DIM)-1:0]  index of the row on Cout.
REQ-012 SHALL have port busy  output  1  high in COLLECT and DRAIN.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a pass completes.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, DRAIN.
REQ-015 IDLE: start=1 -> COLLECT next edge, beat counter k cleared to 0; start in COLLECT/DRAIN SHALL be ignored.
REQ-016 COLLECT: each cycle with in_en=1 is beat k; for every column c with c <= k <= c+DIM-1, SHALL store Cin[c] as element (row k-c, col c).
REQ-017 COLLECT: Cin[c] outside its window SHALL be discarded; cycles with in_en=0 SHALL neither advance k nor write storage.
REQ-018 Beat k = 2*DIM-2 SHALL be the last; on that edge, go to DRAIN with read row pointer rd = 0.
REQ-019 in_en SHALL be ignored in IDLE and DRAIN.
REQ-020 DRAIN: out_valid=1, Cout[c] = element (rd, c), out_row = rd, all driven from registers.
REQ-021 First out_valid SHALL appear the cycle after the final beat is captured (latency 1).
REQ-022 A handshake occurs on a cycle with out_valid=1 and out_ready=1; on each, rd SHALL increment.
REQ-023 While out_valid=1 and out_ready=0, Cout and out_row SHALL remain stable; no row skipped or repeated.
REQ-024 Handshake on row DIM-1 SHALL return FSM to IDLE, with done=1 for exactly the following cycle.
REQ-025 start during the done cycle SHALL be accepted; back-to-back passes need no idle gap.
REQ-026 Cout SHALL be 0 and out_row 0 whenever out_valid=0.
REQ-027 Values SHALL be stored and returned bit-exact; sign preserved; no arithmetic on data.
REQ-028 busy SHALL be 1 exactly when the state is COLLECT or DRAIN.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, k=0, rd=0, out_valid=0, Cout=0, out_row=0, busy=0, done=0, all storage 0.
REQ-030 Reset mid-COLLECT or mid-DRAIN SHALL abandon the pass; no partial row SHALL be emitted afterwards.
REQ-031 After rst_n deasserts, the first start SHALL begin a fresh pass identical to a post-power-up pass.

Verification
REQ-032 DIM=8, start, in_en=1 for 15 beats, Cin[c] at beat k = 16*(k-c)+c inside window, 0x7FFFFF outside -> 8 rows, row r col c = 16r+c; 0x7FFFFF never on Cout; done pulses once.
REQ-033 Same data with in_en toggling 1,0,1,0 -> identical output rows; first out_valid 1 cycle after 15th in_en beat.
REQ-034 out_ready=0 for 3 cycles while out_row=2 -> Cout/out_row frozen at row 2; rows then 3..7 in order, none repeated.
REQ-035 All Cin = -1 (0xFFFFFF) -> every Cout element = 0xFFFFFF; start pulsed during DRAIN -> no effect, busy stays 1.
REQ-036 rst_n low at beat 6 of COLLECT -> out_valid, busy, Cout = 0 at once; new start plus full 15 beats -> correct rows, no stale data.
REQ-037 start in done cycle with second data set -> second pass collects correctly; done pulses twice in total.

Source files
------------

// File: rtl/memc_deskew.sv
// De-skews the diagonally staggered result columns of a DIM x DIM systolic array
// and hands them out one aligned row at a time over a valid/ready port.
module memc_deskew #(
   parameter int BITS_C = 24,
   parameter int DIM    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     in_en,
   input  logic signed [BITS_C-1:0] Cin [DIM],
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic signed [BITS_C-1:0] Cout [DIM],
   output logic [$clog2(DIM)-1:0]   out_row,
   output logic                     busy,
   output logic                     done
);

   localparam int RW = $clog2(DIM);
   localparam int KW = $clog2(2*DIM);
   localparam logic [KW-1:0] K_LAST = KW'(2*DIM-2);
   localparam logic [RW-1:0] R_LAST = RW'(DIM-1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;

   logic [1:0]    state;
   logic [KW-1:0] k;
   logic [RW-1:0] rd;

   logic          beat;
   logic          last_beat;
   logic          hs;
   logic          last_hs;
   logic          load;
   logic [RW-1:0] ld_row;

   // Output handshake: a row transfers on every cycle with out_valid=1 and
   // out_ready=1; while out_ready=0 the presented row and index hold steady.
   assign beat      = (state == COLLECT) && in_en;
   assign last_beat = beat && (k == K_LAST);
   assign hs        = (state == DRAIN) && out_ready;
   assign last_hs   = hs && (rd == R_LAST);
   assign load      = last_beat || (hs && !last_hs);
   assign ld_row    = last_beat ? '0 : rd + RW'(1);

   assign out_valid = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign out_row   = rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
         rd    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= COLLECT;
                  k     <= '0;
               end
            end
            COLLECT: begin
               if (beat) begin
                  if (k == K_LAST) begin
                     state <= DRAIN;
                     k     <= '0;
                     rd    <= '0;
                  end else begin
                     k <= k + KW'(1);
                  end
               end
            end
            DRAIN: begin
               if (hs) begin
                  if (last_hs) begin
                     state <= IDLE;
                     rd    <= '0;
                     done  <= 1'b1;
                  end else begin
                     rd <= rd + RW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               k     <= '0;
               rd    <= '0;
            end
         endcase
      end
   end

   // Column c carries row (k - c) on beat k; the window test is done on a
   // one-bit-wider difference so that k < c shows up as a negative result.
   for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [BITS_C-1:0] col_mem [DIM];
      logic signed [BITS_C-1:0] cout_r;
      logic [KW:0]              diff;
      logic                     in_win;
      logic [RW-1:0]            wr_row;

      assign diff   = {1'b0, k} - (KW+1)'(c);
      assign in_win = !diff[KW] && (diff[KW-1:0] < KW'(DIM));
      assign wr_row = RW'(diff[KW-1:0]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
               col_mem[r] <= '0;
            end
            cout_r <= '0;
         end else begin
            if (beat && in_win) begin
               col_mem[wr_row] <= Cin[c];
            end
            if (load) begin
               cout_r <= col_mem[ld_row];
            end else if (last_hs) begin
               cout_r <= '0;
            end
         end
      end

      assign Cout[c] = cout_r;
   end

endmodule

// File: tb/tb_memc_deskew.sv
// Randomised bench for memc_deskew: the driver pushes each pass's intended rows
// into a queue and a per-cycle compare process checks the output port against it.
module tb_memc_deskew;

   localparam int BITS_C = 24;
   localparam int DIM    = 8;
   localparam int RW     = $clog2(DIM);
   localparam int W      = DIM * BITS_C;
   localparam int NBEAT  = 2*DIM - 1;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     in_en = 1'b0;
   logic signed [BITS_C-1:0] Cin [DIM];
   logic                     out_ready = 1'b1;
   logic                     out_valid;
   logic signed [BITS_C-1:0] Cout [DIM];
   logic [RW-1:0]            out_row;
   logic                     busy;
   logic                     done;

   memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_en     (in_en),
      .Cin       (Cin),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .Cout      (Cout),
      .out_row   (out_row),
      .busy      (busy),
      .done      (done)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [W-1:0] exp_q[$];
   int         m_phase = 0;     // 0 idle, 1 collecting, 2 draining
   int         m_beats = 0;
   int         m_row   = 0;
   bit         m_done  = 1'b0;
   int         done_cnt = 0;
   int         lit_mode = 0;
   int         ready_mode = 0;
   int         stall_left = 0;
   int         row2_cycles = 0;

   task automatic chk_w(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_e(input string name, input logic [BITS_C-1:0] got, input logic [BITS_C-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack_cout();
      logic [W-1:0] v;
      v = '0;
      for (int c = 0; c < DIM; c++) v[c*BITS_C +: BITS_C] = Cout[c];
      return v;
   endfunction

   function automatic logic signed [BITS_C-1:0] junk(input int pat);
      if (pat == 0) return BITS_C'(24'h7FFFFF);
      if (pat == 1) return '1;
      return BITS_C'($urandom);
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [W-1:0] got;
      got = pack_cout();
      if (!rst_n) begin
         chk_i("rst_out_valid", int'(out_valid), 0);
         chk_i("rst_busy", int'(busy), 0);
         chk_i("rst_done", int'(done), 0);
         chk_i("rst_out_row", int'(out_row), 0);
         chk_w("rst_cout", got, '0);
         exp_q.delete();
         m_phase = 0;
         m_beats = 0;
         m_row   = 0;
         m_done  = 1'b0;
      end else begin
         chk_i("out_valid", int'(out_valid), int'(m_phase == 2));
         chk_i("busy", int'(busy), int'(m_phase != 0));
         chk_i("done", int'(done), int'(m_done));
         if (done) done_cnt++;
         if (m_phase == 2) begin
            if (exp_q.size() == 0) chk_i("row_queue_empty", 0, 1);
            else chk_w("cout_row", got, exp_q[0]);
            chk_i("out_row", int'(out_row), m_row);
            if (ready_mode == 2 && out_row == 2) row2_cycles++;
            if (lit_mode == 1) begin
               for (int c = 0; c < DIM; c++) chk_i("no_junk", int'(Cout[c] == BITS_C'(24'h7FFFFF)), 0);
               if (out_row == 3) begin
                  chk_e("lit_r3c5", Cout[5], 24'd53);
                  chk_e("lit_r3c0", Cout[0], 24'd48);
               end
            end
            if (lit_mode == 2) begin
               chk_e("lit_neg_c0", Cout[0], 24'hFFFFFF);
               chk_e("lit_neg_c7", Cout[DIM-1], 24'hFFFFFF);
            end
         end else begin
            chk_w("cout_idle", got, '0);
            chk_i("out_row_idle", int'(out_row), 0);
         end
         // advance the model with the inputs that the coming edge will see
         m_done = 1'b0;
         if (m_phase == 0) begin
            if (start) begin
               m_phase = 1;
               m_beats = 0;
            end
         end else if (m_phase == 1) begin
            if (in_en) begin
               m_beats++;
               if (m_beats == NBEAT) begin
                  m_phase = 2;
                  m_row   = 0;
               end
            end
         end else if (out_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (m_row == DIM-1) begin
               m_phase = 0;
               m_row   = 0;
               m_done  = 1'b1;
            end else begin
               m_row++;
            end
         end
      end
   end

   // ---------------- ready driver ----------------
   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         1: out_ready = 1'($urandom_range(0, 1));
         2: begin
            if (out_valid && out_row == 2 && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
            end
         end
         default: out_ready = 1'b1;
      endcase
   end

   // ---------------- driver tasks ----------------
   task automatic drive_junk();
      for (int c = 0; c < DIM; c++) Cin[c] = BITS_C'($urandom);
   endtask

   task automatic run_pass(input int pat, input int gap, input int abort_k);
      logic signed [BITS_C-1:0] d [DIM][DIM];
      logic [W-1:0] row;
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            if (pat == 0) d[r][c] = BITS_C'(16*r + c);
            else if (pat == 1) d[r][c] = '1;
            else d[r][c] = BITS_C'($urandom);
            row[c*BITS_C +: BITS_C] = d[r][c];
         end
         exp_q.push_back(row);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < NBEAT; k++) begin
         int gaps;
         gaps = (gap == 1 && k > 0) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
         for (int g = 0; g < gaps; g++) begin
            in_en = 1'b0;
            for (int c = 0; c < DIM; c++) Cin[c] = junk(pat);
            @(posedge clk);
            #1;
         end
         in_en = 1'b1;
         for (int c = 0; c < DIM; c++)
            Cin[c] = (k >= c && k - c < DIM) ? d[k-c][c] : junk(pat);
         if (k == abort_k) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk_i("async_rst_valid", int'(out_valid), 0);
            chk_i("async_rst_busy", int'(busy), 0);
            chk_w("async_rst_cout", pack_cout(), '0);
            in_en = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_en = 1'b0;
   endtask

   task automatic wait_done(input bit pulse_start);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            in_en = 1'($urandom_range(0, 1));
            drive_junk();
            start = pulse_start && out_valid && (out_row == 4);
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      in_en = 1'b0;
      chk_i("pass_completed", int'(seen), 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0;
      for (int c = 0; c < DIM; c++) Cin[c] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // known pattern, dense beats
      lit_mode = 1;
      run_pass(0, 0, -1);
      wait_done(1'b0);
      @(posedge clk);
      #1;
      chk_i("done_once", done_cnt, 1);

      // same pattern, in_en toggling
      run_pass(0, 1, -1);
      wait_done(1'b0);
      lit_mode = 0;

      // consumer stall on row 2
      ready_mode = 2;
      stall_left = 3;
      row2_cycles = 0;
      run_pass(2, 0, -1);
      wait_done(1'b0);
      ready_mode = 0;
      chk_i("row2_held_cycles", row2_cycles, 4);

      // all ones, start pulsed during drain
      lit_mode = 2;
      run_pass(1, 0, -1);
      wait_done(1'b1);
      lit_mode = 0;

      // reset at beat 6, then a fresh pass
      @(posedge clk);
      #1;
      run_pass(2, 0, 6);
      @(posedge clk);
      #1;
      run_pass(2, 0, -1);
      wait_done(1'b0);

      // back-to-back passes, second started in the done cycle
      @(posedge clk);
      #1;
      d0 = done_cnt;
      run_pass(2, 2, -1);
      wait_done(1'b0);
      run_pass(2, 0, -1);
      wait_done(1'b0);
      @(posedge clk);
      #1;
      chk_i("b2b_done_pulses", done_cnt - d0, 2);

      // random traffic with random backpressure
      ready_mode = 1;
      for (int p = 0; p < 6; p++) begin
         run_pass(2, $urandom_range(0, 2), -1);
         wait_done(1'b0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      ready_mode = 0;

      repeat (3) @(posedge clk);
      #1;
      chk_i("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
